// File: rtl/sterownik_akumulatora.sv
// sterownik_akumulatora: 3-cycle fetch/decode/execute controller for the accumulator datapath.
module sterownik_akumulatora #(
  parameter int ALU_rozm_data = 8,
  parameter int PC_rozm = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [7:0]               instr_in,
  input  logic                     akum_zero,
  output logic [PC_rozm-1:0]       pc,
  output logic [1:0]               alu_op,
  output logic [ALU_rozm_data-1:0] alu_b,
  output logic                     A_ce,
  output logic                     halted
);
  typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, HALT} state_t;
  state_t state, state_nxt;
  logic [7:0] ir;
  logic [2:0] opc;
  logic [PC_rozm-1:0] pc_nxt;
  logic jump;
  assign opc = ir[7:5];
  assign jump = opc == 3'd5 || (opc == 3'd6 && akum_zero);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc <= '0;
      ir <= '0;
    end else begin
      state <= state_nxt;
      pc <= pc_nxt;
      if (state == DECODE) ir <= instr_in;
    end
  end
  // Outputs depend only on state and IR, so the async reset clears them at once.
  always_comb begin
    state_nxt = state;
    pc_nxt = pc;
    alu_op = 2'b00;
    alu_b = '0;
    A_ce = 1'b0;
    halted = state == HALT;
    case (state)
      FETCH: state_nxt = run ? DECODE : FETCH;
      DECODE: state_nxt = EXECUTE;
      EXECUTE: begin
        state_nxt = opc == 3'd7 ? HALT : FETCH;
        A_ce = opc inside {[3'd1:3'd4]};
        alu_op = A_ce ? 2'(opc - 3'd1) : 2'b00;
        alu_b = ALU_rozm_data'(ir[4:0]);
        pc_nxt = jump ? PC_rozm'(ir[4:0]) : opc == 3'd7 ? pc : pc + 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_sterownik_akumulatora.sv
// tb_sterownik_akumulatora: ROM/ALU/accumulator environment with an instruction-level reference model.
module tb_sterownik_akumulatora;
  logic clk = 0, rst = 1, run = 0, akum_zero;
  logic [7:0] instr_in = 0;
  logic [4:0] pc;
  logic [1:0] alu_op;
  logic [7:0] alu_b;
  logic A_ce, halted;
  logic [7:0] rom [32];
  logic [7:0] acc = 0;
  logic [7:0] m_acc = 0;
  logic [4:0] m_pc = 0;
  int checks = 0, errors = 0;

  sterownik_akumulatora #(.ALU_rozm_data(8), .PC_rozm(5)) dut (
    .clk(clk), .rst(rst), .run(run), .instr_in(instr_in), .akum_zero(akum_zero),
    .pc(pc), .alu_op(alu_op), .alu_b(alu_b), .A_ce(A_ce), .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) instr_in <= rom[pc];
  always @(posedge clk)
    if (A_ce)
      acc <= alu_op == 2'd0 ? alu_b : alu_op == 2'd1 ? acc + alu_b : alu_op == 2'd2 ? acc - alu_b : acc & alu_b;
  assign akum_zero = acc == 0;

  function automatic logic [7:0] ins(input int opc, input int imm);
    return {3'(opc), 5'(imm)};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #3 rst = 1;
    @(negedge clk);
    rst = 0;
    m_pc = 0;
  endtask

  // Executes one instruction at the instruction level and checks the three controller cycles.
  task automatic step(input int hold, input bit drop);
    logic [7:0] w;
    logic [2:0] o;
    logic [4:0] imm;
    logic [1:0] eop;
    logic ece;
    w = rom[m_pc];
    o = w[7:5];
    imm = w[4:0];
    ece = o >= 1 && o <= 4;
    eop = ece ? 2'(o - 3'd1) : 2'd0;
    checks++;
    if (pc !== m_pc || A_ce !== 1'b0 || halted !== 1'b0 || alu_op !== 2'd0 || alu_b !== 8'd0) begin
      errors++;
      $display("FAIL fetch: pc=%0d A_ce=%b halted=%b alu_op=%b alu_b=%0d, expected pc=%0d A_ce=0 halted=0 alu_op=00 alu_b=0",
               pc, A_ce, halted, alu_op, alu_b, m_pc);
    end
    run = hold == 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (pc !== m_pc || A_ce !== 1'b0) begin
        errors++;
        $display("FAIL hold: pc=%0d A_ce=%b, expected pc=%0d A_ce=0", pc, A_ce, m_pc);
      end
    end
    run = 1;
    @(negedge clk);
    checks++;
    if (A_ce !== 1'b0 || alu_op !== 2'd0 || alu_b !== 8'd0 || pc !== m_pc) begin
      errors++;
      $display("FAIL decode: pc=%0d A_ce=%b alu_op=%b alu_b=%0d, expected pc=%0d A_ce=0 alu_op=00 alu_b=0",
               pc, A_ce, alu_op, alu_b, m_pc);
    end
    if (drop) run = 0;
    @(negedge clk);
    checks++;
    if (A_ce !== ece || alu_op !== eop || (ece && alu_b !== {3'b0, imm}) || halted !== 1'b0) begin
      errors++;
      $display("FAIL execute op%0d: A_ce=%b alu_op=%b alu_b=%0d halted=%b, expected A_ce=%b alu_op=%b alu_b=%0d halted=0",
               o, A_ce, alu_op, alu_b, halted, ece, eop, imm);
    end
    case (o)
      3'd1: m_acc = {3'b0, imm};
      3'd2: m_acc = m_acc + {3'b0, imm};
      3'd3: m_acc = m_acc - {3'b0, imm};
      3'd4: m_acc = m_acc & {3'b0, imm};
      default: ;
    endcase
    m_pc = o == 5 || (o == 6 && m_acc == 0) ? imm : o == 7 ? m_pc : m_pc + 5'd1;
    @(negedge clk);
    checks++;
    if (acc !== m_acc) begin
      errors++;
      $display("FAIL accumulator: acc=%0d, expected %0d", acc, m_acc);
    end
    if (o == 7) begin
      checks++;
      if (halted !== 1'b1 || A_ce !== 1'b0 || pc !== m_pc) begin
        errors++;
        $display("FAIL halt entry: halted=%b A_ce=%b pc=%0d, expected halted=1 A_ce=0 pc=%0d", halted, A_ce, pc, m_pc);
      end
    end
  endtask

  task automatic test_alu_sequence();
    clear_rom();
    rom[0] = ins(1, 5); rom[1] = ins(2, 3); rom[2] = ins(3, 8); rom[3] = ins(4, 7); rom[4] = ins(7, 0);
    apply_reset();
    for (int i = 0; i < 5; i++) step(0, 0);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3 rst = 1;
    #1;
    checks++;
    if (pc !== 5'd0 || A_ce !== 1'b0 || halted !== 1'b0 || alu_op !== 2'd0 || alu_b !== 8'd0) begin
      errors++;
      $display("FAIL async reset: pc=%0d A_ce=%b halted=%b alu_op=%b alu_b=%0d, expected all zero", pc, A_ce, halted, alu_op, alu_b);
    end
    @(negedge clk);
    rst = 0;
    m_pc = 0;
    step(0, 0);
  endtask

  task automatic test_branch();
    clear_rom();
    rom[0] = ins(1, 0); rom[1] = ins(6, 10); rom[10] = ins(1, 1); rom[11] = ins(6, 0); rom[12] = ins(7, 0);
    apply_reset();
    for (int i = 0; i < 5; i++) step(0, 0);
    for (int i = 0; i < 4; i++) begin
      run = 1'($urandom);
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || pc !== 5'd12 || A_ce !== 1'b0) begin
        errors++;
        $display("FAIL halted hold: halted=%b pc=%0d A_ce=%b, expected halted=1 pc=12 A_ce=0", halted, pc, A_ce);
      end
    end
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[0] = ins(5, 31); rom[31] = ins(0, 0);
    apply_reset();
    for (int i = 0; i < 3; i++) step(0, 0);
  endtask

  task automatic test_run_hold();
    clear_rom();
    apply_reset();
    step(0, 0); step(0, 0); step(5, 0); step(0, 1); step(2, 0);
  endtask

  task automatic test_rst_in_execute();
    clear_rom();
    rom[0] = ins(1, 4); rom[1] = ins(2, 3);
    apply_reset();
    step(0, 0);
    run = 1;
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1;
    #1;
    checks++;
    if (A_ce !== 1'b0 || pc !== 5'd0 || alu_op !== 2'd0) begin
      errors++;
      $display("FAIL reset in execute: A_ce=%b pc=%0d alu_op=%b, expected A_ce=0 pc=0 alu_op=00", A_ce, pc, alu_op);
    end
    @(negedge clk);
    checks++;
    if (acc !== m_acc) begin
      errors++;
      $display("FAIL accumulator after reset: acc=%0d, expected %0d", acc, m_acc);
    end
    rst = 0;
    m_pc = 0;
    step(0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 32; i++) begin
      rom[i] = 8'($urandom);
      if (rom[i][7:5] == 3'd7) rom[i][7:5] = 3'($urandom_range(0, 6));
    end
    apply_reset();
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0, $urandom_range(0, 5) == 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    repeat (2) @(negedge clk);
    rst = 0;
    test_alu_sequence();
    test_reset();
    test_branch();
    test_wrap();
    test_run_hold();
    test_rst_in_execute();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sterownik_akumulatora.md
# sterownik_akumulatora

Multi-cycle control unit for the accumulator datapath of the microprocessor. Fetches 8-bit instructions from program ROM, decodes them and sequences the ALU and the `Akumulator` register (`A_ce`, ALU operation, immediate operand), including conditional branching on the accumulator-zero flag. Sits between program ROM, ALU and accumulator; one instruction completes every 3 clock cycles.

## Interface
- `ALU_rozm_data`, default 8: ALU/accumulator data width; must be ≥ 5.
- `PC_rozm`, fixed 5: program-counter width, equal to the instruction immediate field width.

- `clk`  input  1  system clock, all state changes on rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `run`  input  1  enable; when low the FSM holds in FETCH.
- `instr_in`  input  8  ROM read data; synchronous ROM, valid the cycle after `pc` is presented.
- `akum_zero`  input  1  high when accumulator output == 0.
- `pc`  output  PC_rozm  ROM address (registered).
- `alu_op`  output  2  00 pass B, 01 A+B, 10 A−B, 11 A&B.
- `alu_b`  output  ALU_rozm_data  immediate, zero-extended from `IR[4:0]`.
- `A_ce`  output  1  accumulator load enable, one-cycle pulse.
- `halted`  output  1  high while in HALT.

## Operation
- Instruction format: `[7:5]` opcode, `[4:0]` imm/addr.
- Opcodes: 000 NOP; 001 LDI (A←imm); 010 ADDI (A←A+imm); 011 SUBI (A←A−imm); 100 ANDI (A←A&imm); 101 JMP addr; 110 JZ addr (jump if `akum_zero`); 111 HLT.
- ALU arithmetic is modulo 2^ALU_rozm_data; carry/borrow discarded (block only selects; ALU computes).
- States: FETCH → DECODE → EXECUTE → FETCH; HLT in EXECUTE → HALT.
- FETCH: `pc` presented to ROM; advance to DECODE only if `run`=1, else stay (pc held).
- DECODE: `IR` ← `instr_in`.
- EXECUTE: `alu_op`/`alu_b` decoded from `IR`; `A_ce`=1 only for LDI/ADDI/SUBI/ANDI. PC update at end of EXECUTE: JMP → addr; JZ taken → addr; JZ not taken, NOP, ALU ops → pc+1; HLT → pc unchanged.
- PC wraps 31 → 0 without flag.
- HALT: `halted`=1, `A_ce`=0, pc frozen; left only by `rst`. `run` ignored.
- `alu_op`=00 and `alu_b`=0 outside EXECUTE.
- Reset values: state FETCH, `pc`=0, `IR`=0, `A_ce`=0, `alu_op`=00, `alu_b`=0, `halted`=0.

## Timing
- Instruction latency 3 cycles; accumulator captures result on the rising edge ending EXECUTE.
- `akum_zero` sampled in EXECUTE; it reflects the previous instruction's write (2 cycles settled), so LDI 0 followed by JZ takes the jump.
- `A_ce` is combinational from state+IR, high exactly one cycle per ALU instruction, never glitching into FETCH/DECODE.
- `run` deasserted in DECODE/EXECUTE: current instruction completes; hold begins at next FETCH.
- `rst` asserted at any time (incl. mid-EXECUTE with `A_ce`=1): all outputs go to reset values immediately, without waiting for `clk`; first fetch from address 0 on the first edge after release.

## Test plan
- Reset: assert `rst` asynchronously between edges → `pc`=0, `A_ce`=0, `halted`=0 before next edge; after release, first ROM address 0.
- ALU sequence ROM: LDI 5, ADDI 3, SUBI 8, ANDI 7 → `A_ce` pulses at cycles 3,6,9,12; `alu_op` 00/01/10/11, `alu_b` 5/3/8/7; accumulator 5, 8, 0, 0.
- Branch: LDI 0, JZ 10, (addr 10) LDI 1, JZ 0, HLT → jump to 10 taken, second JZ not taken (pc 11→12), `halted`=1, pc stays 12.
- Wrap: JMP 31 with NOP at 31 → pc sequence 31, 0.
- `run` low for 5 cycles in FETCH at pc=2 → pc held at 2, no `A_ce`; resumes in DECODE one cycle after `run`=1.
- `rst` pulse during EXECUTE of ADDI → `A_ce` drops immediately, accumulator not loaded by controller, execution restarts at pc 0.
